mem_bus_arbiter: RTL and testbench

//  Shares the single 256-bit memory bus (address, nRead, nWrite, write data) between NUM_REQ masters.

---
 rtl/mem_bus_pkg.sv | 17 +
 rtl/mem_bus_arbiter_rr_picker.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WAIT,
    DONE
  } arb_state_t;

  typedef logic [15:0]  bus_addr_t;
  typedef logic [255:0] bus_data_t;

  // Largest supported memory read latency; sizes the WAIT counter.
  localparam int unsigned RD_LAT_MAX = 3;

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner selection.
// Build option ARB_FIXED_PRIO_EN: master 0 always wins when requesting and
// the rotating search covers masters 1..NUM_REQ-1 only.
module rr_picker #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winnerIdx
);

  logic [NUM_REQ-1:0] searchReq;
  logic               found;
  int unsigned        cand;

  // Search from the pointer upward, wrapping at NUM_REQ; first requester wins.
  always_comb begin
    winner    = '0;
    winnerIdx = '0;
    found     = 1'b0;
    searchReq = req;
    cand      = 0;
`ifdef ARB_FIXED_PRIO_EN
    if (req[0]) begin
      found     = 1'b1;
      winner[0] = 1'b1;
    end
    // Master 0 is handled above, so the rotation never lands on it.
    searchReq[0] = 1'b0;
`endif
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(pointer) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!found && searchReq[cand]) begin
        found        = 1'b1;
        winner[cand] = 1'b1;
        winnerIdx    = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of the single memory bus between
// NUM_REQ masters, one complete read or write per grant.
// Build option ARB_FIXED_PRIO_EN gives master 0 absolute priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = $bits(bus_addr_t),
  parameter int unsigned DATA_W  = $bits(bus_data_t),
  parameter int unsigned RD_LAT  = 1
) (
  input  logic                      Clk,
  input  logic                      nReset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         address,
  output logic                      nRead,
  output logic                      nWrite,
  output logic [DATA_W-1:0]         ExeDataOut,
  input  logic [DATA_W-1:0]         MemDataOut
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT_MAX + 1);

  arb_state_t         state;
  arb_state_t         stateNext;
  logic [IDX_W-1:0]   rrPtr;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   pickIdx;
  logic [NUM_REQ-1:0] pickOneHot;
  logic               grantWr;
  logic [CNT_W-1:0]   waitCnt;
  logic               startTxn;
  logic               endStrobe;
  logic               captureRd;
  logic               finishTxn;
  logic [ADDR_W-1:0]  addrArr  [NUM_REQ];
  logic [DATA_W-1:0]  wdataArr [NUM_REQ];

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) uPicker (
    .req       (req),
    .pointer   (rrPtr),
    .winner    (pickOneHot),
    .winnerIdx (pickIdx)
  );

  // Unpack the per-master address and write-data buses.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      addrArr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdataArr[i] = req_wdata[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    stateNext = state;
    startTxn  = 1'b0;
    endStrobe = 1'b0;
    captureRd = 1'b0;
    finishTxn = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          startTxn  = 1'b1;
          stateNext = GRANT;
        end
      end
      GRANT: begin
        endStrobe = 1'b1;
        stateNext = grantWr ? DONE : WAIT;
      end
      WAIT: begin
        if (waitCnt == CNT_W'(RD_LAT - 1)) begin
          captureRd = 1'b1;
          stateNext = DONE;
        end
      end
      DONE: begin
        finishTxn = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Registered bus outputs: the grant, address and strobe are loaded on the
  // edge leaving IDLE so they are visible for the whole GRANT cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      gnt        <= '0;
      ack        <= '0;
      rdata      <= '0;
      address    <= '0;
      nRead      <= 1'b1;
      nWrite     <= 1'b1;
      ExeDataOut <= '0;
      rrPtr      <= '0;
      grantIdx   <= '0;
      grantWr    <= 1'b0;
      waitCnt    <= '0;
    end else begin
      ack <= '0;
      if (startTxn) begin
        gnt        <= pickOneHot;
        grantIdx   <= pickIdx;
        grantWr    <= req_wr[pickIdx];
        address    <= addrArr[pickIdx];
        ExeDataOut <= wdataArr[pickIdx];
        nWrite     <= !req_wr[pickIdx];
        nRead      <= req_wr[pickIdx];
      end
      if (endStrobe) begin
        nRead   <= 1'b1;
        nWrite  <= 1'b1;
        waitCnt <= '0;
      end
      if (state == WAIT) begin
        waitCnt <= waitCnt + 1'b1;
      end
      if (captureRd) begin
        rdata <= MemDataOut;
      end
      if (finishTxn) begin
        ack   <= gnt;
        gnt   <= '0;
        rrPtr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: transaction-level arbitration model,
// behavioural memory, decoupled driver and monitor.
module tb_mem_bus_arbiter;

  localparam int unsigned NUM_REQ = 3;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned RD_LAT  = 1;
  localparam int unsigned MEM_N   = 64;

  logic                      Clk = 1'b0;
  logic                      nReset;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_wr;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        ack;
  logic [DATA_W-1:0]         rdata;
  logic [ADDR_W-1:0]         address;
  logic                      nRead;
  logic                      nWrite;
  logic [DATA_W-1:0]         ExeDataOut;
  logic [DATA_W-1:0]         MemDataOut;

  mem_bus_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RD_LAT  (RD_LAT)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .req        (req),
    .req_wr     (req_wr),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .ack        (ack),
    .rdata      (rdata),
    .address    (address),
    .nRead      (nRead),
    .nWrite     (nWrite),
    .ExeDataOut (ExeDataOut),
    .MemDataOut (MemDataOut)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  typedef struct {
    int unsigned       master;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    bit                first;
  } exp_t;

  txn_t        pendQ [NUM_REQ][$];
  exp_t        expQ[$];
  logic [DATA_W-1:0] refMem [MEM_N];
  logic [DATA_W-1:0] busMem [MEM_N];
  logic [DATA_W-1:0] rdPipe [RD_LAT];
  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned cyc = 0;
  int unsigned roundStart = 0;
  int unsigned modelPtr = 0;
  bit          monEn = 1'b0;
  bit          aborted = 1'b0;

  function automatic logic [DATA_W-1:0] memInit(input int unsigned a);
    return {16{a[15:0]}};
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge Clk) cyc <= cyc + 1;

  // Behavioural memory: writes land on the strobe edge, reads appear RD_LAT
  // cycles after the read strobe cycle.
  always @(posedge Clk) begin
    if (!nWrite) busMem[address[5:0]] <= ExeDataOut;
    rdPipe[0] <= !nRead ? busMem[address[5:0]] : '0;
    for (int i = 1; i < int'(RD_LAT); i++) rdPipe[i] <= rdPipe[i-1];
  end
  assign MemDataOut = rdPipe[RD_LAT-1];

  // Reference arbitration: next master to be served given pending counts.
  function automatic int unsigned pickModel(input int unsigned rem[NUM_REQ]);
`ifdef ARB_FIXED_PRIO_EN
    if (rem[0] > 0) return 0;
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      int unsigned c;
      c = (modelPtr + k) % NUM_REQ;
`ifdef ARB_FIXED_PRIO_EN
      if (c == 0) continue;
`endif
      if (rem[c] > 0) return c;
    end
    return 0;
  endfunction

  task automatic present(input int unsigned m);
    req[m]                        = 1'b1;
    req_wr[m]                     = pendQ[m][0].wr;
    req_addr[m*ADDR_W +: ADDR_W]  = pendQ[m][0].addr;
    req_wdata[m*DATA_W +: DATA_W] = pendQ[m][0].data;
  endtask

  // Predict the service order of everything queued, then drive it.
  task automatic runRound();
    int unsigned rem [NUM_REQ];
    int unsigned idx [NUM_REQ];
    int unsigned left;
    int unsigned k;
    bit          first;
    exp_t        e;
    txn_t        t;
    first = 1'b1;
    left  = 0;
    for (int unsigned m = 0; m < NUM_REQ; m++) begin
      rem[m] = pendQ[m].size();
      idx[m] = 0;
      left += rem[m];
    end
    while (left > 0) begin
      int unsigned w;
      w = pickModel(rem);
      t = pendQ[w][idx[w]];
      e.master = w;
      e.wr     = t.wr;
      e.addr   = t.addr;
      e.wdata  = t.data;
      e.first  = first;
      e.rdata  = refMem[t.addr[5:0]];
      if (t.wr) refMem[t.addr[5:0]] = t.data;
      expQ.push_back(e);
      first = 1'b0;
      idx[w]++;
      rem[w]--;
      left--;
      modelPtr = (w + 1) % NUM_REQ;
    end
    @(negedge Clk);
    roundStart = cyc;
    for (int unsigned m = 0; m < NUM_REQ; m++) begin
      if (pendQ[m].size() > 0) present(m);
      else req[m] = 1'b0;
    end
    k = 0;
    left = 1;
    while (left > 0 && k < 400) begin
      @(negedge Clk);
      k++;
      left = 0;
      for (int unsigned m = 0; m < NUM_REQ; m++) begin
        if (ack[m] && pendQ[m].size() > 0) begin
          void'(pendQ[m].pop_front());
          if (pendQ[m].size() > 0) present(m);
          else req[m] = 1'b0;
        end
        left += pendQ[m].size();
      end
    end
    chk("roundTimeout", DATA_W'(left), '0);
    if (left > 0) begin
      aborted = 1'b1;
      for (int unsigned m = 0; m < NUM_REQ; m++) pendQ[m].delete();
      req = '0;
    end
    repeat (2) @(negedge Clk);
  endtask

  function automatic txn_t randTxn();
    txn_t t;
    t.wr   = 1'($urandom_range(0, 1));
    t.addr = ADDR_W'($urandom_range(0, 15));
    for (int w = 0; w < 8; w++) t.data[w*32 +: 32] = $urandom;
    return t;
  endfunction

  // Monitor: protocol rules every cycle, bus strobes and acks against the
  // scoreboard head.
  logic [NUM_REQ-1:0] prevGnt;
  logic [NUM_REQ-1:0] prevAck;
  bit                 prevStrobe;
  bit                 strobe;
  int unsigned        strobeCyc;
  exp_t               me;
  always @(negedge Clk) begin
    if (!nReset || !monEn) begin
      prevGnt    = '0;
      prevAck    = '0;
      prevStrobe = 1'b0;
    end else begin
      strobe = !nRead || !nWrite;
      chk("gntOneHot0", DATA_W'($onehot0(gnt)), DATA_W'(1));
      chk("rdWrExclusive", DATA_W'(!nRead && !nWrite), '0);
      if (strobe) begin
        chk("strobeGap", DATA_W'(prevStrobe), '0);
        if (expQ.size() == 0) begin
          chk("strobeExpected", DATA_W'(expQ.size()), DATA_W'(1));
        end else begin
          me = expQ[0];
          chk("strobeGnt", DATA_W'(gnt), DATA_W'(NUM_REQ'(1) << me.master));
          chk("strobeKind", DATA_W'(!nWrite), DATA_W'(me.wr));
          chk("strobeAddr", DATA_W'(address), DATA_W'(me.addr));
          if (me.wr) chk("strobeWdata", ExeDataOut, me.wdata);
          strobeCyc = cyc;
        end
      end
      if (ack != '0) begin
        chk("ackOwner", DATA_W'(ack), DATA_W'(prevGnt));
        chk("ackPulse", DATA_W'(prevAck), '0);
        if (expQ.size() == 0) begin
          chk("ackExpected", DATA_W'(expQ.size()), DATA_W'(1));
        end else begin
          me = expQ.pop_front();
          chk("ackMaster", DATA_W'(ack), DATA_W'(NUM_REQ'(1) << me.master));
          if (!me.wr) chk("rdata", rdata, me.rdata);
          chk("strobeToAck", DATA_W'(cyc - strobeCyc),
              DATA_W'(me.wr ? 2 : 2 + RD_LAT));
          if (me.first) chk("reqToAck", DATA_W'(cyc - roundStart),
                            DATA_W'(me.wr ? 3 : 3 + RD_LAT));
        end
      end
      prevGnt    = gnt;
      prevAck    = ack;
      prevStrobe = strobe;
    end
  end

  initial begin
    txn_t t;
    int unsigned n;
    for (int i = 0; i < int'(MEM_N); i++) begin
      refMem[i] = memInit(i);
      busMem[i] = memInit(i);
    end
    refMem[6'h20] = 256'h1234;
    busMem[6'h20] = 256'h1234;
    nReset = 1'b0;
    req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge Clk);
    chk("rstGnt", DATA_W'(gnt), '0);
    chk("rstAck", DATA_W'(ack), '0);
    chk("rstRdata", rdata, '0);
    chk("rstAddress", DATA_W'(address), '0);
    chk("rstStrobes", DATA_W'({nRead, nWrite}), DATA_W'(2'b11));
    chk("rstWdata", ExeDataOut, '0);
    nReset = 1'b1;

    // Read from master 0 abandoned by reset while waiting for memory.
    @(negedge Clk);
    req[0] = 1'b1; req_wr[0] = 1'b0; req_addr[ADDR_W-1:0] = 16'h0010;
    n = 0;
    while (nRead && n < 10) begin
      @(negedge Clk);
      n++;
    end
    chk("rstTestStrobe", DATA_W'(nRead), '0);
    @(posedge Clk);
    #1;
    chk("rstTestGntHeld", DATA_W'(gnt), DATA_W'(1));
    nReset = 1'b0;
    req = '0;
    #1;
    chk("asyncRstGnt", DATA_W'(gnt), '0);
    chk("asyncRstNRead", DATA_W'(nRead), DATA_W'(1));
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      chk("noAckAfterAbort", DATA_W'({ack, gnt}), '0);
    end
    monEn = 1'b1;

    // Single write from master 1.
    t.wr = 1'b1; t.addr = 16'h0005; t.data = 256'hA5;
    pendQ[1].push_back(t);
    runRound();

    // Single read from master 0 of a preloaded location.
    t.wr = 1'b0; t.addr = 16'h0020; t.data = '0;
    pendQ[0].push_back(t);
    runRound();

    // Masters 0 and 1 contend for four transactions each.
    for (int i = 0; i < 4; i++) begin
      pendQ[0].push_back(randTxn());
      pendQ[1].push_back(randTxn());
    end
    runRound();

    // Random mixes of simultaneous requesters.
    for (int r = 0; r < 40 && !aborted; r++) begin
      n = 0;
      for (int unsigned m = 0; m < NUM_REQ; m++) begin
        int unsigned cnt;
        cnt = $urandom_range(0, 2);
        for (int unsigned j = 0; j < cnt; j++) pendQ[m].push_back(randTxn());
        n += cnt;
      end
      if (n == 0) pendQ[$urandom_range(0, NUM_REQ-1)].push_back(randTxn());
      runRound();
    end

    chk("scoreboardDrained", DATA_W'(expQ.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
